// File: rtl/ysyx_25020037_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface ysyx_25020037_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: one memory request per accepted instruction, aligned and
// extended load data, one-cycle pass-through for non-memory instructions.
module ysyx_25020037_lsu #(
    parameter int PASS_WD = 96,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_exu_valid,
    output logic               o_lsu_ready,
    input  logic               i_is_load,
    input  logic               i_is_store,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  logic [PASS_WD-1:0] i_pass_in,
    ysyx_25020037_lsu_if.master mem,
    output logic               o_lsu_valid,
    input  logic               i_wbu_ready,
    output logic [31:0]        o_lsu_result,
    output logic [31:0]        o_rdata_processed,
    output logic [PASS_WD-1:0] o_pass_out,
    output logic               o_lsu_err
);
    localparam int CNT_WD = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    // Access size code: 0 byte, 1 half, 2 word (unlisted encodings act as word).
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = 2'd0;
            3'b001, 3'b101: size_of = 2'd1;
            default:        size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'd0, sh[7:0]};
            3'b101:  load_ext = {16'd0, sh[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            2'd0:    store_strb = 4'b0001 << off;
            2'd1:    store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            2'd0:    store_data = {4{wd[7:0]}};
            2'd1:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_WD-1:0]   r_cnt;
    logic                r_is_load;
    logic [2:0]          r_funct3;
    logic [1:0]          r_off;
    logic [31:0]         r_addr;
    logic [31:0]         r_req_addr;
    logic                r_req_wen;
    logic [31:0]         r_req_wdata;
    logic [3:0]          r_req_wstrb;
    logic [31:0]         r_result;
    logic [31:0]         r_rdata_proc;
    logic [PASS_WD-1:0]  r_pass;
    logic                r_err;

    logic                w_hs;
    logic                w_is_mem;
    logic                w_misalign;
    logic                w_resp_take;
    logic                w_timeout;
    logic [1:0]          w_size;
    logic [31:0]         w_ld_val;

    assign w_hs      = i_exu_valid && (r_state == S_IDLE);
    assign w_is_mem  = i_is_load || i_is_store;
    assign w_size    = size_of(i_funct3);
    assign w_misalign = w_is_mem && (((w_size == 2'd1) && i_addr[0]) ||
                                     ((w_size == 2'd2) && (i_addr[1:0] != 2'b00)));
    assign w_ld_val  = load_ext(r_funct3, r_off, mem.mem_resp_rdata);

    assign o_lsu_ready       = (r_state == S_IDLE);
    assign o_lsu_valid       = (r_state == S_OUT);
    assign mem.mem_req_valid = (r_state == S_REQ);
    assign mem.mem_req_addr  = r_req_addr;
    assign mem.mem_req_wen   = r_req_wen;
    assign mem.mem_req_wdata = r_req_wdata;
    assign mem.mem_req_wstrb = r_req_wstrb;
    assign o_lsu_result      = r_result;
    assign o_rdata_processed = r_rdata_proc;
    assign o_pass_out        = r_pass;
    assign o_lsu_err         = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; a response coincident with request acceptance skips WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_take = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_nxt = (w_is_mem && !w_misalign) ? S_REQ : S_OUT;
                else      w_state_nxt = S_IDLE;
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    w_resp_take = mem.mem_resp_valid;
                    w_state_nxt = mem.mem_resp_valid ? S_OUT : S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem.mem_resp_valid) begin
                    w_resp_take = 1'b1;
                    w_state_nxt = S_OUT;
                end else if (r_cnt == CNT_WD'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_OUT: begin
                if (i_wbu_ready) w_state_nxt = S_IDLE;
                else             w_state_nxt = S_OUT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the instruction, hold request fields, capture the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= {CNT_WD{1'b0}};
            r_is_load    <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_addr       <= 32'd0;
            r_req_addr   <= 32'd0;
            r_req_wen    <= 1'b0;
            r_req_wdata  <= 32'd0;
            r_req_wstrb  <= 4'd0;
            r_result     <= 32'd0;
            r_rdata_proc <= 32'd0;
            r_pass       <= {PASS_WD{1'b0}};
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_is_load   <= i_is_load;
                        r_funct3    <= i_funct3;
                        r_off       <= i_addr[1:0];
                        r_addr      <= i_addr;
                        r_pass      <= i_pass_in;
                        r_req_addr  <= {i_addr[31:2], 2'b00};
                        r_req_wen   <= i_is_store;
                        r_req_wdata <= store_data(i_funct3, i_wdata);
                        r_req_wstrb <= i_is_store ? store_strb(i_funct3, i_addr[1:0]) : 4'd0;
                        r_err       <= w_misalign;
                        r_result    <= w_is_mem ? 32'd0 : i_addr;
                        if (w_misalign && i_is_load) r_rdata_proc <= 32'd0;
                    end
                end
                S_REQ:   if (mem.mem_req_ready) r_cnt <= {CNT_WD{1'b0}};
                S_WAIT:  r_cnt <= r_cnt + CNT_WD'(1);
                default: ;
            endcase
            if (w_resp_take) begin
                r_err    <= mem.mem_resp_err;
                r_result <= mem.mem_resp_err ? 32'd0 : (r_is_load ? w_ld_val : r_addr);
                if (r_is_load) r_rdata_proc <= mem.mem_resp_err ? 32'd0 : w_ld_val;
            end
            if (w_timeout) begin
                r_err    <= 1'b1;
                r_result <= 32'd0;
                if (r_is_load) r_rdata_proc <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Randomised bench for the LSU with an arithmetic reference model and a
// behavioural memory that applies configurable accept/response/write-back delays.
module tb_ysyx_25020037_lsu;
    localparam int PASS_WD = 96;
    localparam int TIMEOUT = 255;
    localparam int BUDGET  = 400;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_exu_valid, i_is_load, i_is_store, i_wbu_ready;
    logic [2:0]         i_funct3;
    logic [31:0]        i_addr, i_wdata;
    logic [PASS_WD-1:0] i_pass_in;
    logic               o_lsu_ready, o_lsu_valid, o_lsu_err;
    logic [31:0]        o_lsu_result, o_rdata_processed;
    logic [PASS_WD-1:0] o_pass_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rp  = 32'd0;

    ysyx_25020037_lsu_if mem_bus ();

    ysyx_25020037_lsu #(.PASS_WD(PASS_WD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_exu_valid(i_exu_valid), .o_lsu_ready(o_lsu_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_pass_in(i_pass_in),
        .mem(mem_bus),
        .o_lsu_valid(o_lsu_valid), .i_wbu_ready(i_wbu_ready),
        .o_lsu_result(o_lsu_result), .o_rdata_processed(o_rdata_processed),
        .o_pass_out(o_pass_out), .o_lsu_err(o_lsu_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_idle();
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = 32'd0;
        mem_bus.mem_resp_err   = 1'b0;
    endtask

    // op: 0 non-memory, 1 load, 2 store. rq: cycles before accept; rs: cycles from
    // accept to response (0 = same cycle); wb: cycles of write-back stall.
    task automatic run_txn(input int op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                           input int rq, input int rs, input int wb, input bit noresp);
        int size, off, e_lat, cycles;
        bit is_mem, mis, req_done, resp_done;
        longint lv;
        logic [31:0] ld, e_res, e_addr, e_wdata, new_rp;
        logic [3:0]  e_strb;
        logic        e_err;
        logic [PASS_WD-1:0] pass;

        size   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        off    = int'(addr[1:0]);
        is_mem = (op != 0);
        mis    = is_mem && ((off % size) != 0);
        e_addr = addr & 32'hFFFF_FFFC;
        e_strb = (op == 2) ? 4'(((1 << size) - 1) << off) : 4'd0;
        e_wdata = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
                  (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
        lv = longint'(rdata) >> (8 * off);
        if (size < 4) begin
            lv = lv % (longint'(1) << (8 * size));
            if (f3 < 3'd4 && lv >= (longint'(1) << (8 * size - 1)))
                lv = lv - (longint'(1) << (8 * size));
        end
        ld = lv[31:0];
        pass = {$urandom, $urandom, $urandom};
        new_rp = exp_rp;

        if (mis) begin
            e_err = 1'b1; e_res = 32'd0; e_lat = 0;
            if (op == 1) new_rp = 32'd0;
        end else if (!is_mem) begin
            e_err = 1'b0; e_res = addr; e_lat = 0;
        end else if (noresp) begin
            e_err = 1'b1; e_res = 32'd0; e_lat = rq + 1 + TIMEOUT;
            if (op == 1) new_rp = 32'd0;
        end else begin
            e_err = rerr;
            e_res = rerr ? 32'd0 : ((op == 1) ? ld : addr);
            e_lat = rq + 1 + rs;
            if (op == 1) new_rp = rerr ? 32'd0 : ld;
        end

        @(negedge clk);
        check_eq("ready_before", o_lsu_ready, 1'b1);
        i_exu_valid = 1'b1; i_is_load = (op == 1); i_is_store = (op == 2);
        i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_pass_in = pass;
        @(negedge clk);
        // Scramble the execute-side inputs so the DUT must have latched them.
        i_exu_valid = 1'b0; i_is_load = $urandom_range(0, 1); i_is_store = $urandom_range(0, 1);
        i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom; i_pass_in = {$urandom, $urandom, $urandom};

        cycles = 0; req_done = 1'b0; resp_done = 1'b0;
        while (o_lsu_valid !== 1'b1 && cycles < BUDGET) begin
            mem_idle();
            mem_bus.mem_resp_rdata = $urandom;
            check_eq("busy_ready", o_lsu_ready, 1'b0);
            check_eq("req_valid", mem_bus.mem_req_valid, is_mem && !mis && !req_done);
            if (is_mem && !mis && !req_done) begin
                check_eq("req_addr", mem_bus.mem_req_addr, e_addr);
                check_eq("req_wen", mem_bus.mem_req_wen, op == 2);
                check_eq("req_wstrb", mem_bus.mem_req_wstrb, e_strb);
                if (op == 2) check_eq("req_wdata", mem_bus.mem_req_wdata, e_wdata);
                if (rq > 0) rq--;
                else begin
                    mem_bus.mem_req_ready = 1'b1;
                    req_done = 1'b1;
                    if (rs == 0 && !noresp) begin
                        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = rdata;
                        mem_bus.mem_resp_err = rerr; resp_done = 1'b1;
                    end
                end
            end else if (req_done && !resp_done && !noresp) begin
                rs--;
                if (rs == 0) begin
                    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = rdata;
                    mem_bus.mem_resp_err = rerr; resp_done = 1'b1;
                end
            end
            @(negedge clk);
            cycles++;
        end
        mem_idle();
        check_eq("latency", cycles, e_lat);

        for (int i = 0; i <= wb; i++) begin
            check_eq("lsu_valid", o_lsu_valid, 1'b1);
            check_eq("lsu_result", o_lsu_result, e_res);
            check_eq("lsu_err", o_lsu_err, e_err);
            check_eq("pass_out", o_pass_out, pass);
            check_eq("out_ready", o_lsu_ready, 1'b0);
            check_eq("out_req", mem_bus.mem_req_valid, 1'b0);
            i_wbu_ready = (i == wb);
            @(negedge clk);
        end
        i_wbu_ready = 1'b0;
        exp_rp = new_rp;
        check_eq("rdata_proc", o_rdata_processed, exp_rp);
        check_eq("ready_after", o_lsu_ready, 1'b1);
        check_eq("valid_after", o_lsu_valid, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, o_lsu_ready, 1'b1);
        check_eq({tag, "_valid"}, o_lsu_valid, 1'b0);
        check_eq({tag, "_result"}, o_lsu_result, 32'd0);
        check_eq({tag, "_err"}, o_lsu_err, 1'b0);
        check_eq({tag, "_rp"}, o_rdata_processed, 32'd0);
        check_eq({tag, "_pass"}, o_pass_out, {PASS_WD{1'b0}});
        check_eq({tag, "_reqv"}, mem_bus.mem_req_valid, 1'b0);
        check_eq({tag, "_reqa"}, mem_bus.mem_req_addr, 32'd0);
        check_eq({tag, "_strb"}, mem_bus.mem_req_wstrb, 4'd0);
    endtask

    // Reset while waiting for a load response, then deliver the stale response.
    task automatic reset_in_wait();
        @(negedge clk);
        i_exu_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h8000_0040; i_pass_in = {3{32'hDEAD_BEEF}};
        @(negedge clk);
        i_exu_valid = 1'b0; i_is_load = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_idle();
        check_eq("rw_in_wait", mem_bus.mem_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rp = 32'd0;
        check_reset_state("rw");
        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_idle();
        check_eq("late_valid", o_lsu_valid, 1'b0);
        check_eq("late_rp", o_rdata_processed, 32'd0);
        @(negedge clk);
        check_eq("late_valid2", o_lsu_valid, 1'b0);
        check_eq("late_ready", o_lsu_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; i_exu_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0; i_wbu_ready = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0; i_pass_in = {PASS_WD{1'b0}};
        mem_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        run_txn(0, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_0000, 1'b0, 0, 1, 0, 1'b0);
        check_eq("lb_value", o_rdata_processed, 32'hFFFF_FF80);
        run_txn(1, 3'b100, 32'h8000_0003, 32'd0, 32'h80FF_0000, 1'b0, 0, 1, 0, 1'b0);
        check_eq("lbu_value", o_rdata_processed, 32'h0000_0080);
        run_txn(2, 3'b001, 32'h8000_0002, 32'hAABB_CCDD, 32'd0, 1'b0, 0, 1, 0, 1'b0);
        run_txn(1, 3'b010, 32'h8000_0001, 32'd0, 32'h5555_5555, 1'b0, 0, 1, 0, 1'b0);
        run_txn(1, 3'b010, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 1'b0, 5, 2, 3, 1'b0);
        run_txn(1, 3'b101, 32'h8000_0022, 32'd0, 32'h8001_7FFF, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1, 3'b010, 32'h8000_0020, 32'd0, 32'd0, 1'b0, 1, 0, 1, 1'b1);
        run_txn(1, 3'b001, 32'h8000_0006, 32'd0, 32'hFFFF_0000, 1'b1, 0, 2, 0, 1'b0);
        reset_in_wait();

        for (int t = 0; t < 200; t++) begin
            int op, sz;
            logic [2:0]  f3;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            f3 = 3'($urandom);
            a  = $urandom;
            sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            run_txn(op, f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
